// File: rtl/nabp_sinogram_lane_addresser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nabp_sinogram_lane_addresser_pkg
// Brief   : Shared state encoding and helpers for the multi-lane addresser.
// Revision: 1.0 - initial release
// ============================================================================
package nabp_sinogram_lane_addresser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEEK = 2'd1,
    ST_WORK = 2'd2,
    ST_DONE = 2'd3
  } sg_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nabp_sg_lane_addr.sv
`default_nettype none
// ============================================================================
// Module  : nabp_sg_lane_addr
// Brief   : One lane: applies the s-offset, range-checks it, registers the address.
// Revision: 1.0 - initial release
// ============================================================================
module nabp_sg_lane_addr #(
  parameter int S_W       = 9,
  parameter int ADDR_W    = 17,
  parameter int LINE_SIZE = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [S_W-1:0]      s_val,
  input  logic signed [S_W:0] s_offset,
  input  logic [ADDR_W-1:0]   base,
  output logic [ADDR_W-1:0]   addr,
  output logic                addr_valid
);

  logic signed [S_W+1:0] w_t;
  logic                  w_in_range;

  assign w_t = $signed({2'b00, s_val}) + $signed({s_offset[S_W], s_offset});
  // Rejecting out-of-line t keeps an address from spilling into the next projection line.
  assign w_in_range = !w_t[S_W+1] && (w_t < $signed((S_W+2)'(LINE_SIZE)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr       <= '0;
      addr_valid <= 1'b0;
    end else if (en && w_in_range) begin
      addr       <= base + ADDR_W'($unsigned(w_t));
      addr_valid <= 1'b1;
    end else begin
      addr       <= '0;
      addr_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nabp_sinogram_lane_addresser.sv
`default_nettype none
// ============================================================================
// Module  : nabp_sinogram_lane_addresser
// Brief   : Sweeps an angle window in NUM_LANES-wide groups, emits lane addresses.
// Revision: 1.0 - initial release
// ============================================================================
module nabp_sinogram_lane_addresser
  import nabp_sinogram_lane_addresser_pkg::*;
#(
  parameter int NUM_LANES    = 2,
  parameter int ANGLE_W      = 9,
  parameter int S_W          = 9,
  parameter int ADDR_W       = 17,
  parameter int NO_OF_ANGLES = 180,
  parameter int LINE_SIZE    = 256,
  parameter int ANGLE_STEP   = 1,
  parameter int ANGLE_180    = 180
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           hs_kick,
  input  logic [ANGLE_W-1:0]             hs_angle_start,
  input  logic [ANGLE_W:0]               hs_angle_count,
  input  logic signed [S_W:0]            hs_s_offset,
  output logic                           hs_busy,
  output logic                           hs_done,
  input  logic                           fr_next_angle,
  input  logic [NUM_LANES*S_W-1:0]       fr_s_val,
  output logic [NUM_LANES*ANGLE_W-1:0]   fr_angle,
  output logic [NUM_LANES-1:0]           fr_lane_valid,
  output logic                           fr_has_next_angle,
  output logic                           fr_next_angle_ack,
  output logic [NUM_LANES*ADDR_W-1:0]    sg_addr,
  output logic [NUM_LANES-1:0]           sg_addr_valid
);

  localparam int C_BASE_WRAP = NO_OF_ANGLES * LINE_SIZE;

  sg_state_t             r_state, w_next;
  logic [ANGLE_W-1:0]    r_start, r_seek_cnt;
  logic [ANGLE_W:0]      r_groups_left;
  logic [NUM_LANES-1:0]  r_last_mask, w_kick_mask, w_lane_valid;
  logic signed [S_W:0]   r_s_offset;
  logic [ANGLE_W-1:0]    r_angle [NUM_LANES];
  logic [ADDR_W-1:0]     r_base  [NUM_LANES];
  logic                  w_kick, w_seek_step, w_has_next, w_ack;
  int                    w_rem;

  function automatic logic [ANGLE_W-1:0] wrap_angle(input logic [ANGLE_W-1:0] a, input int inc);
    logic [ANGLE_W:0] sum;
    sum = {1'b0, a} + (ANGLE_W+1)'(inc);
    if (sum >= (ANGLE_W+1)'(ANGLE_180)) sum = sum - (ANGLE_W+1)'(ANGLE_180);
    return sum[ANGLE_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_base(input logic [ADDR_W-1:0] b, input int inc);
    logic [ADDR_W:0] sum;
    sum = {1'b0, b} + (ADDR_W+1)'(inc);
    if (sum >= (ADDR_W+1)'(C_BASE_WRAP)) sum = sum - (ADDR_W+1)'(C_BASE_WRAP);
    return sum[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_kick       = 1'b0;
    w_seek_step  = 1'b0;
    w_has_next   = 1'b0;
    w_ack        = 1'b0;
    w_lane_valid = '0;
    case (r_state)
      ST_IDLE: begin
        if (hs_kick) begin
          w_kick = 1'b1;
          w_next = (hs_angle_count == '0) ? ST_DONE : ST_SEEK;
        end
      end
      ST_SEEK: begin
        // Step first, then leave as soon as the step lands on start: max(start,1) cycles.
        if (r_seek_cnt == r_start) begin
          w_next = ST_WORK;
        end else begin
          w_seek_step = 1'b1;
          if (r_seek_cnt + ANGLE_W'(1) == r_start) w_next = ST_WORK;
        end
      end
      ST_WORK: begin
        w_has_next   = (r_groups_left > (ANGLE_W+1)'(1));
        w_lane_valid = w_has_next ? '1 : r_last_mask;
        if (fr_next_angle) begin
          if (w_has_next) w_ack  = 1'b1;
          else            w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rem       = int'(hs_angle_count) % NUM_LANES;
    w_kick_mask = '1;
    if (w_rem != 0) w_kick_mask = NUM_LANES'((1 << w_rem) - 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start       <= '0;
      r_seek_cnt    <= '0;
      r_groups_left <= '0;
      r_last_mask   <= '0;
      r_s_offset    <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        r_angle[k] <= '0;
        r_base[k]  <= '0;
      end
    end else begin
      if (w_kick) begin
        r_start       <= ANGLE_W'(int'(hs_angle_start) % NO_OF_ANGLES);
        r_seek_cnt    <= '0;
        r_groups_left <= (ANGLE_W+1)'(ceil_div(int'(hs_angle_count), NUM_LANES));
        r_last_mask   <= w_kick_mask;
        r_s_offset    <= hs_s_offset;
        for (int k = 0; k < NUM_LANES; k++) begin
          r_angle[k] <= ANGLE_W'((k % NO_OF_ANGLES) * ANGLE_STEP);
          r_base[k]  <= ADDR_W'((k % NO_OF_ANGLES) * LINE_SIZE);
        end
      end
      if (w_seek_step) begin
        r_seek_cnt <= r_seek_cnt + ANGLE_W'(1);
        for (int k = 0; k < NUM_LANES; k++) begin
          r_angle[k] <= wrap_angle(r_angle[k], ANGLE_STEP);
          r_base[k]  <= wrap_base(r_base[k], LINE_SIZE);
        end
      end
      if (w_ack) begin
        r_groups_left <= r_groups_left - (ANGLE_W+1)'(1);
        for (int k = 0; k < NUM_LANES; k++) begin
          r_angle[k] <= wrap_angle(r_angle[k], NUM_LANES * ANGLE_STEP);
          r_base[k]  <= wrap_base(r_base[k], NUM_LANES * LINE_SIZE);
        end
      end
    end
  end

  assign hs_busy           = (r_state != ST_IDLE);
  assign hs_done           = (r_state == ST_DONE);
  assign fr_has_next_angle = w_has_next;
  assign fr_next_angle_ack = w_ack;
  assign fr_lane_valid     = w_lane_valid;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign fr_angle[k*ANGLE_W +: ANGLE_W] = w_lane_valid[k] ? r_angle[k] : '0;

    nabp_sg_lane_addr #(
      .S_W       (S_W),
      .ADDR_W    (ADDR_W),
      .LINE_SIZE (LINE_SIZE)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (w_lane_valid[k]),
      .s_val      (fr_s_val[k*S_W +: S_W]),
      .s_offset   (r_s_offset),
      .base       (r_base[k]),
      .addr       (sg_addr[k*ADDR_W +: ADDR_W]),
      .addr_valid (sg_addr_valid[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_nabp_sinogram_lane_addresser.sv
`default_nettype none
// ============================================================================
// Module  : tb_nabp_sinogram_lane_addresser
// Brief   : Randomized sweeps against a window-level model of the addresser.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nabp_sinogram_lane_addresser;

  localparam int NL = 2, AW = 9, SW = 9, DW = 17, N = 6, LS = 8, STEP = 30, A180 = 180;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               hs_kick = 1'b0;
  logic [AW-1:0]      hs_angle_start = '0;
  logic [AW:0]        hs_angle_count = '0;
  logic signed [SW:0] hs_s_offset = '0;
  logic               hs_busy, hs_done;
  logic               fr_next_angle = 1'b0;
  logic [NL*SW-1:0]   fr_s_val = '0;
  logic [NL*AW-1:0]   fr_angle;
  logic [NL-1:0]      fr_lane_valid;
  logic               fr_has_next_angle, fr_next_angle_ack;
  logic [NL*DW-1:0]   sg_addr;
  logic [NL-1:0]      sg_addr_valid;

  int n_total = 0;
  int n_bad   = 0;

  nabp_sinogram_lane_addresser #(
    .NUM_LANES(NL), .ANGLE_W(AW), .S_W(SW), .ADDR_W(DW), .NO_OF_ANGLES(N),
    .LINE_SIZE(LS), .ANGLE_STEP(STEP), .ANGLE_180(A180)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hs_kick(hs_kick), .hs_angle_start(hs_angle_start),
    .hs_angle_count(hs_angle_count), .hs_s_offset(hs_s_offset), .hs_busy(hs_busy),
    .hs_done(hs_done), .fr_next_angle(fr_next_angle), .fr_s_val(fr_s_val),
    .fr_angle(fr_angle), .fr_lane_valid(fr_lane_valid), .fr_has_next_angle(fr_has_next_angle),
    .fr_next_angle_ack(fr_next_angle_ack), .sg_addr(sg_addr), .sg_addr_valid(sg_addr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: lane k of group g sweeps window element j=g*NL+k, index (start+j) mod N.
  task automatic run_sweep(input int start, input int cnt, input int off,
                           input bit fix_s, input int s0, input int s1, input bit poke);
    int st, groups, lat, g, guard;
    int sv [NL];
    int eaddr [NL];
    bit evalid [NL];
    logic [NL-1:0] emask;
    bit nxt;
    st = start % N;
    hs_angle_start = start[AW-1:0];
    hs_angle_count = cnt[AW:0];
    hs_s_offset    = off[SW:0];
    hs_kick        = 1'b1;
    @(negedge clk);
    hs_kick = 1'b0;
    if (cnt == 0) begin
      chk("zero_done", hs_done, 1);
      chk("zero_lanes", fr_lane_valid, 0);
      @(negedge clk);
      chk("zero_done_end", hs_done, 0);
      chk("zero_idle", hs_busy, 0);
      return;
    end
    lat = 1;
    while (fr_lane_valid == '0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("seek_latency", lat, (st > 1 ? st : 1) + 1);
    if (lat >= 200) return;
    groups = (cnt + NL - 1) / NL;
    g = 0;
    guard = 0;
    while (g < groups) begin
      emask = '0;
      for (int k = 0; k < NL; k++) begin
        int j, idx, t;
        j   = g * NL + k;
        idx = (st + j) % N;
        emask[k] = (j < cnt);
        chk("angle", fr_angle[k*AW +: AW], emask[k] ? idx * STEP : 0);
        sv[k] = fix_s ? (k == 0 ? s0 : s1) : $urandom_range(0, 15);
        t = sv[k] + off;
        evalid[k] = emask[k] && t >= 0 && t < LS;
        eaddr[k]  = evalid[k] ? idx * LS + t : 0;
        fr_s_val[k*SW +: SW] = sv[k][SW-1:0];
      end
      chk("lane_valid", fr_lane_valid, emask);
      chk("has_next", fr_has_next_angle, g < groups - 1);
      chk("busy", hs_busy, 1);
      nxt = (guard > 20) || ($urandom_range(0, 2) != 0);
      fr_next_angle  = nxt;
      hs_kick        = poke && ($urandom_range(0, 3) == 0);
      hs_angle_start = AW'($urandom_range(0, 5));
      hs_angle_count = (AW+1)'($urandom_range(0, 6));
      #1;
      chk("ack", fr_next_angle_ack, nxt && (g < groups - 1));
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        chk("sg_addr", sg_addr[k*DW +: DW], eaddr[k]);
        chk("sg_valid", sg_addr_valid[k], evalid[k]);
      end
      if (nxt) g++;
      guard++;
    end
    fr_next_angle = 1'b0;
    hs_kick       = 1'b0;
    chk("done_pulse", hs_done, 1);
    chk("done_lanes", fr_lane_valid, 0);
    @(negedge clk);
    chk("done_end", hs_done, 0);
    chk("idle_busy", hs_busy, 0);
  endtask

  initial begin
    int lat;
    #1;
    chk("rst_busy", hs_busy, 0);
    chk("rst_done", hs_done, 0);
    chk("rst_lanes", fr_lane_valid, 0);
    chk("rst_sg_valid", sg_addr_valid, 0);
    chk("rst_sg_addr", sg_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 6, 0, 0, 0, 0, 0);
    run_sweep(5, 3, 0, 0, 0, 0, 0);
    run_sweep(1, 4, -2, 1, 1, 5, 0);
    run_sweep(2, 0, 0, 0, 0, 0, 0);
    run_sweep(3, 6, 3, 1, 5, 4, 1);
    run_sweep(13, 5, 0, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++)
      run_sweep($urandom_range(0, 40), $urandom_range(0, 6), $urandom_range(0, 18) - 9,
                0, 0, 0, $urandom_range(0, 1));

    // Reset in the middle of WORK: everything drops at once, no done pulse.
    hs_angle_start = 9'd2;
    hs_angle_count = 10'd6;
    hs_s_offset    = '0;
    hs_kick        = 1'b1;
    @(negedge clk);
    hs_kick = 1'b0;
    lat = 0;
    while (fr_lane_valid == '0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_work_reached", lat < 50, 1);
    fr_s_val = {9'd3, 9'd3};
    @(negedge clk);
    chk("mid_sg_addr", sg_addr, {17'd27, 17'd19});
    chk("mid_sg_valid", sg_addr_valid, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", hs_busy, 0);
    chk("arst_lanes", fr_lane_valid, 0);
    chk("arst_angle", fr_angle, 0);
    chk("arst_sg_valid", sg_addr_valid, 0);
    chk("arst_sg_addr", sg_addr, 0);
    @(negedge clk);
    chk("arst_no_done", hs_done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_idle", hs_busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
